// File: rtl/aud_pkg.sv
// Shared types and helpers for the PWM audio streamer.
// Holds the playback FSM encoding and the midscale duty helper.
package aud_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } aud_state_e;

  // Duty that produces a 50% waveform for a given counter width.
  function automatic logic [15:0] midscale(input int unsigned width);
    return 16'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/aud_fifo.sv
// Synchronous sample-frame FIFO with flush and occupancy level.
// Read data is show-ahead: rdata always presents the oldest frame.
module aud_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [LW-1:0]    lvl_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (lvl_q == LW'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign level   = lvl_q;
  assign rdata   = mem[rd_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

endmodule

// File: rtl/aud_pwm_stream.sv
// Streaming multi-channel PWM audio player.
// Frames flow through a FIFO and are latched into duty registers once per PWM period.
module aud_pwm_stream
  import aud_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int PRESCALE   = 1
) (
  input  logic                           clk,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_data_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  output logic [CHANNELS-1:0]            aud_pwm_o,
  output logic                           busy_o,
  output logic                           underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]    level_o
);

  localparam int FW = CHANNELS * DATA_WIDTH;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0]         PS_LAST = PW'(PRESCALE - 1);
  localparam logic [DATA_WIDTH-1:0] MID     =
    DATA_WIDTH'(midscale(DATA_WIDTH));

  aud_state_e state_q;
  aud_state_e state_d;

  logic [DATA_WIDTH-1:0] count_q;
  logic [PW-1:0]         presc_q;
  logic [DATA_WIDTH-1:0] duty_q [CHANNELS];
  logic                  underrun_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_rdata;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  tick;
  logic                  wrap;
  logic                  load_frame;
  logic                  load_mid;
  logic                  ur_set;
  logic                  ur_clr;
  logic                  cnt_clr;

  assign s_ready_o  = !fifo_full && !stop_i;
  assign push       = s_valid_i && s_ready_o;
  assign busy_o     = (state_q != ST_IDLE);
  assign underrun_o = underrun_q;

  aud_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (s_data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    flush      = 1'b0;
    tick       = 1'b0;
    wrap       = 1'b0;
    load_frame = 1'b0;
    load_mid   = 1'b0;
    ur_set     = 1'b0;
    ur_clr     = 1'b0;
    cnt_clr    = 1'b0;
    // Stop dominates every state, including a coincident start.
    if (stop_i) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_PRIME;
            ur_clr  = 1'b1;
          end
        end
        ST_PRIME: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            load_frame = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = ST_PLAY;
          end
        end
        ST_PLAY: begin
          tick = (presc_q == PS_LAST);
          wrap = tick && (count_q == CNT_MAX);
          if (wrap) begin
            if (!fifo_empty) begin
              pop        = 1'b1;
              load_frame = 1'b1;
            end else begin
              load_mid = 1'b1;
              ur_set   = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      count_q    <= '0;
      presc_q    <= '0;
      underrun_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        duty_q[k] <= '0;
      end
    end else begin
      if (cnt_clr) begin
        count_q <= '0;
        presc_q <= '0;
      end else if (state_q == ST_PLAY) begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          count_q <= count_q + DATA_WIDTH'(1);
        end
      end
      unique case (1'b1)
        load_frame: begin
          for (int k = 0; k < CHANNELS; k++) begin
            duty_q[k] <= fifo_rdata[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        load_mid: begin
          for (int k = 0; k < CHANNELS; k++) begin
            duty_q[k] <= MID;
          end
        end
        default: ;
      endcase
      unique case (1'b1)
        ur_set:  underrun_q <= 1'b1;
        ur_clr:  underrun_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    aud_pwm_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      aud_pwm_o[k] = (state_q == ST_PLAY) && (count_q < duty_q[k]);
    end
  end

endmodule

// File: doc/aud_pwm_stream.md
AUD_PWM_STREAM -- requirements
Module: aud_pwm_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning sample and PWM counter width in bits (4..16).
REQ-002 The block SHALL have parameter CHANNELS, default 2, meaning number of independent PWM outputs (1..8).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning sample-frame FIFO depth (power of 2, >=2).
REQ-004 The block SHALL have parameter PRESCALE, default 1, meaning clk cycles per PWM count step (>=1).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port start_i, input, 1, meaning a playback start pulse.
REQ-008 The block SHALL have port stop_i, input, 1, meaning a playback stop pulse.
REQ-009 The block SHALL have port s_data_i, input, CHANNELS*DATA_WIDTH, meaning one frame; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port s_valid_i, input, 1, meaning frame valid.
REQ-011 The block SHALL have port s_ready_o, output, 1, meaning frame accepted when high together with s_valid_i.
REQ-012 The block SHALL have port aud_pwm_o, output, CHANNELS, meaning the per-channel PWM outputs.
REQ-013 The block SHALL have port busy_o, output, 1, meaning the block is in PRIME or PLAY.
REQ-014 The block SHALL have port underrun_o, output, 1, meaning the sticky underrun flag.
REQ-015 The block SHALL have port level_o, output, $clog2(FIFO_DEPTH)+1, meaning the FIFO occupancy in frames.

Function
REQ-016 s_ready_o SHALL equal (FIFO not full) AND NOT stop_i; a push occurs when s_valid_i and s_ready_o are both high, in any state.
REQ-017 The FSM SHALL have states IDLE, PRIME and PLAY.
REQ-018 In IDLE, start_i SHALL move the FSM to PRIME on the next cycle and clear underrun_o.
REQ-019 In PRIME with the FIFO non-empty, the block SHALL pop one frame into the duty registers, clear count and prescaler, and enter PLAY on the next cycle.
REQ-020 In PRIME with the FIFO empty, the block SHALL wait.
REQ-021 In PLAY, the prescaler SHALL count 0..PRESCALE-1, and count SHALL advance by 1 on each prescaler terminal, wrapping at 2^DATA_WIDTH-1 -> 0.
REQ-022 The PWM period SHALL be 2^DATA_WIDTH*PRESCALE clk cycles.
REQ-023 At the count wrap with the FIFO non-empty, the next frame SHALL be popped and loaded so that it takes effect at count 0.
REQ-024 At the count wrap with the FIFO empty, every duty register SHALL load midscale 2^(DATA_WIDTH-1) and underrun_o SHALL set; playback SHALL continue.
REQ-025 aud_pwm_o[k] SHALL be combinational: (state==PLAY) AND (count < duty[k]).
REQ-026 A duty of 0 SHALL give a constant low output; a duty of 2^DATA_WIDTH-1 SHALL give high for all but one count step per period.
REQ-027 stop_i in any state SHALL take the FSM to IDLE on the next cycle, flush the FIFO (level 0) and clear count; it SHALL NOT clear underrun_o.
REQ-028 When start_i and stop_i are high in the same cycle, stop_i SHALL win.
REQ-029 start_i SHALL be ignored outside IDLE.
REQ-030 A push and a pop in the same cycle SHALL leave the level unchanged; a pop SHALL NOT make s_ready_o high in that same cycle.
REQ-031 Latency: with the FIFO non-empty, start_i at cycle N SHALL make aud_pwm_o reflect the first frame from cycle N+2.

Reset
REQ-032 On rst_i high at a clock edge, the block SHALL set: state IDLE, FIFO empty, count/prescaler/duty 0, underrun_o 0, busy_o 0, level_o 0, aud_pwm_o 0, and s_ready_o 1 once rst_i is low.
REQ-033 rst_i SHALL override start_i, stop_i and pushes in the same cycle.
REQ-034 rst_i asserted mid-playback SHALL behave identically to rst_i asserted from IDLE.

Structure
REQ-035 Package aud_pkg SHALL hold the FSM state typedef (IDLE/PRIME/PLAY) and the midscale helper function.
REQ-036 The FIFO SHALL be a sub-module aud_fifo (synchronous, parameterised width/depth, with push, pop, flush, full, empty and level).
REQ-037 The counter, FSM and comparators SHALL reside in aud_pwm_stream.

Verification (DATA_WIDTH=8, CHANNELS=2, FIFO_DEPTH=4, PRESCALE=1 unless stated)
REQ-038 Scenario: reset -> aud_pwm_o=0, busy_o=0, underrun_o=0, level_o=0, s_ready_o=1.
REQ-039 Scenario: push {ch1=192, ch0=64}, then start_i -> from cycle N+2, ch0 high 64 and ch1 high 192 of each 256 cycles; with PRESCALE=3, ch0 high 192 of 768 cycles.
REQ-040 Scenario: frame {ch1=255, ch0=0} -> ch0 never high, ch1 high 255 of 256.
REQ-041 Scenario: one frame then none -> the second period has both channels high 128 of 256 and underrun_o=1 until stop_i followed by start_i.
REQ-042 Scenario: 5 pushes without start -> level_o=4, s_ready_o=0 and the 5th frame is not accepted; after start_i, the first pop returns level_o to 3 and s_ready_o to 1 the next cycle.
REQ-043 Scenario: stop_i with start_i mid-period -> next cycle aud_pwm_o=0, busy_o=0, level_o=0, FSM in IDLE.
